// File: rtl/op_word_receiver_node0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | op_word_receiver_node0: assembles host bytes into 16-bit op words, filters |
// | malformed words, buffers them and issues one word per slot on idx_op.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module op_word_receiver_node0 #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BYTE_TIMEOUT = 255,
  parameter int ISSUE_GAP    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  input  logic                          op_ready,
  output logic [15:0]                   idx_op,
  output logic                          idx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_frame,
  output logic                          err_overflow
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_TMR_W   = $clog2(BYTE_TIMEOUT + 1);
  localparam int c_GAP_W   = $clog2(ISSUE_GAP + 2);

  typedef enum logic [1:0] {
    S_WAIT_HI = 2'd0,
    S_WAIT_LO = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          word_q, word_d;
  logic [c_TMR_W-1:0]   timer_q, timer_d;

  logic [15:0]          mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]   count_q;
  logic [c_GAP_W-1:0]   gap_q;

  logic [15:0]          idx_op_q;
  logic                 idx_valid_q;
  logic                 err_frame_q;
  logic                 err_ovf_q;

  logic                 w_timeout;
  logic                 w_check;
  logic                 w_nib_bad;
  logic                 w_word_ok;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_ovf;
  logic                 w_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_HI;
      word_q  <= 16'h0000;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      timer_q <= timer_d;
    end
  end

  // A byte arriving during CHECK starts the next word straight away.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    timer_d   = timer_q;
    w_timeout = 1'b0;
    case (state_q)
      S_WAIT_HI: begin
        if (rx_valid) begin
          word_d[15:8] = rx_byte;
          timer_d      = '0;
          state_d      = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (rx_valid) begin
          word_d[7:0] = rx_byte;
          state_d     = S_CHECK;
        end else if (timer_q == c_TMR_W'(BYTE_TIMEOUT)) begin
          w_timeout = 1'b1;
          state_d   = S_WAIT_HI;
        end else begin
          timer_d = timer_q + c_TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          word_d[15:8] = rx_byte;
          timer_d      = '0;
          state_d      = S_WAIT_LO;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      default: state_d = S_WAIT_HI;
    endcase
  end

  assign w_check   = (state_q == S_CHECK);
  assign w_nib_bad = (word_q[11:8] == 4'h7) || (word_q[11:8] == 4'h8) ||
                     (word_q[11:8] == 4'h9) || (word_q[11:8] == 4'hD) ||
                     (word_q[11:8] == 4'hE) || (word_q[11:8] == 4'hF);
  assign w_word_ok = (word_q[15:12] == 4'h0) && !w_nib_bad;

  assign w_full  = (count_q == c_CNT_W'(FIFO_DEPTH));
  assign w_pop   = (count_q != '0) && op_ready && (gap_q == '0);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push  = w_check && w_word_ok && (!w_full || w_pop);
  assign w_ovf   = w_check && w_word_ok && w_full && !w_pop;
  assign w_frame = w_timeout || (w_check && !w_word_ok);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_W'(1);
        2'b01:   count_q <= count_q - c_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q       <= '0;
      idx_op_q    <= 16'h0000;
      idx_valid_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (w_pop) begin
        gap_q <= c_GAP_W'(ISSUE_GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - c_GAP_W'(1);
      end
      idx_op_q    <= w_pop ? mem_q[rd_ptr_q] : 16'h0000;
      idx_valid_q <= w_pop;
      err_frame_q <= w_frame;
      err_ovf_q   <= w_ovf;
    end
  end

  assign idx_op       = idx_op_q;
  assign idx_valid    = idx_valid_q;
  assign fifo_count   = count_q;
  assign err_frame    = err_frame_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire
